// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// bcd_pkg: shared types, constants and digit helpers for the serial BCD adder
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic       OP_ADD  = 1'b0;
    localparam logic       OP_SUB  = 1'b1;

    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// bcd_serial_adder_ctrl_if: request/response bundle between issuer and serial BCD adder
interface bcd_serial_adder_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  op;
    logic                  cin;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   result;
    logic                  cout;
    logic                  err;

    modport master (
        output start, op, cin, a, b,
        input  busy, done, result, cout, err
    );

    modport slave (
        input  start, op, cin, a, b,
        output busy, done, result, cout, err
    );
endinterface

// File: rtl/bcd_serial_adder_ctrl_digit_add.sv
// bcd_digit_add: combinational single-digit BCD adder with decimal carry
module bcd_digit_add (
    input  logic       Cin,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [3:0] S,
    output logic       Cout
);
    logic [4:0] bin;

    // binary sum, corrected by +6 whenever it leaves the decimal range
    always_comb begin
        bin  = {1'b0, x} + {1'b0, y} + {4'b0, Cin};
        Cout = bin[4] || (bin > 5'd9);
        S    = Cout ? bin[3:0] + 4'd6 : bin[3:0];
    end
endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl: digit-serial packed-BCD add/subtract sequencer around one digit adder
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_serial_adder_ctrl_if.slave bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          state, state_nx;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            cout_r;
    logic            err_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    res_r;
    logic [W-1:0]    b_in;
    logic            in_ok;
    logic            accept;
    logic            last;
    logic [3:0]      x_d;
    logic [3:0]      y_d;
    logic [3:0]      sum_d;
    logic            c_d;

    // operand screening and subtrahend preparation (nines' complement for subtract)
    always_comb begin
        b_in  = '0;
        in_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            b_in[4*i +: 4] = (bus.op == OP_SUB) ? nines_comp(bus.b[4*i +: 4]) : bus.b[4*i +: 4];
            if (bus.a[4*i +: 4] > BCD_MAX || bus.b[4*i +: 4] > BCD_MAX) in_ok = 1'b0;
        end
    end

    assign accept = bus.start && (state != RUN);
    assign last   = (idx == IW'(DIGITS - 1));
    assign x_d    = a_r[{idx, 2'b00} +: 4];
    assign y_d    = b_r[{idx, 2'b00} +: 4];

    bcd_digit_add u_digit (
        .Cin  (carry),
        .x    (x_d),
        .y    (y_d),
        .S    (sum_d),
        .Cout (c_d)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next state: a new request may enter from IDLE or DONE; bad digits skip straight to DONE
    always_comb begin
        state_nx = state;
        if (accept)             state_nx = in_ok ? RUN : DONE;
        else if (state == RUN)  state_nx = last ? DONE : RUN;
        else if (state == DONE) state_nx = IDLE;
    end

    // operand latch, digit walk and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            res_r  <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (accept) begin
            a_r    <= bus.a;
            b_r    <= b_in;
            res_r  <= '0;
            idx    <= '0;
            carry  <= (bus.op == OP_ADD) ? bus.cin : 1'b1;
            cout_r <= 1'b0;
            err_r  <= !in_ok;
        end else if (state == RUN) begin
            res_r[{idx, 2'b00} +: 4] <= sum_d;
            carry <= c_d;
            if (last) cout_r <= c_d;
            else      idx    <= idx + 1'b1;
        end
    end

    assign bus.busy   = (state == RUN);
    assign bus.done   = (state == DONE);
    assign bus.result = res_r;
    assign bus.cout   = cout_r;
    assign bus.err    = err_r;
endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb_bcd_serial_adder_ctrl: decimal-arithmetic reference model checked every cycle plus directed cases
module tb_bcd_serial_adder_ctrl;
    localparam int D   = 4;
    localparam int POW = 10000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_serial_adder_ctrl_if #(.DIGITS(D)) bus();

    bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_at = -100;
    int busy_len = 0;
    int done_at = -100;
    int res_from = 0;
    logic [15:0] exp_res = '0;
    logic exp_cout = 1'b0;
    logic exp_err = 1'b0;
    logic [17:0] m;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    function automatic int dec(input logic [15:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // {err, cout, result} from plain decimal arithmetic
    function automatic logic [17:0] ref_calc(input logic [15:0] a, input logic [15:0] b, input logic op, input logic cin);
        int v;
        for (int i = 0; i < D; i++)
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) return {1'b1, 1'b0, 16'h0};
        if (!op) begin
            v = dec(a) + dec(b) + int'(cin);
            return {1'b0, v >= POW, to_bcd(v % POW)};
        end
        v = dec(a) - dec(b);
        return {1'b0, v >= 0, to_bcd(v < 0 ? v + POW : v)};
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] r;
        for (int i = 0; i < D; i++)
            r[4*i +: 4] = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        return r;
    endfunction

    // model: a request taken at edge k keeps busy for DIGITS cycles and answers at k+DIGITS (k for bad digits)
    always @(posedge clk) begin
        if (!rst_n) begin
            acc_at = -100; busy_len = 0; done_at = -100;
            exp_res = '0; exp_cout = 1'b0; exp_err = 1'b0;
            res_from = cyc + 1;
        end else if (bus.start && !(cyc >= acc_at && cyc < acc_at + busy_len)) begin
            m = ref_calc(bus.a, bus.b, bus.op, bus.cin);
            {exp_err, exp_cout, exp_res} = m;
            acc_at   = cyc + 1;
            busy_len = m[17] ? 0 : D;
            done_at  = cyc + 1 + busy_len;
            res_from = done_at;
        end
        cyc++;
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", bus.busy, cyc >= acc_at && cyc < acc_at + busy_len);
        chk("done", bus.done, cyc == done_at);
        chk("busy_done_excl", bus.busy & bus.done, 0);
        if (cyc >= res_from) begin
            chk("result", bus.result, exp_res);
            chk("cout", bus.cout, exp_cout);
            chk("err", bus.err, exp_err);
        end
    end

    task automatic wait_done(input string n);
        int t = 0;
        while (!bus.done && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({n, "_wait"}, t < 20, 1);
    endtask

    task automatic run_req(input string n, input logic [15:0] a, input logic [15:0] b, input logic op, input logic cin,
                           input logic [15:0] er, input logic ec, input logic ee);
        int lat = 0;
        int bc = 0;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.op = op; bus.cin = cin; bus.start = 1'b1;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.start = 1'b0;
            bc += int'(bus.busy);
        end while (!bus.done && lat < 20);
        chk({n, "_lat"}, lat, ee ? 1 : D + 1);
        chk({n, "_busycyc"}, bc, ee ? 0 : D);
        chk({n, "_res"}, bus.result, er);
        chk({n, "_cout"}, bus.cout, ec);
        chk({n, "_err"}, bus.err, ee);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
        chk("model_add", ref_calc(16'h1234, 16'h5678, 1'b0, 1'b0), {2'b00, 16'h6912});
        chk("model_ripple", ref_calc(16'h9999, 16'h0001, 1'b0, 1'b0), {2'b01, 16'h0000});
        chk("model_sub_pos", ref_calc(16'h5000, 16'h1234, 1'b1, 1'b0), {2'b01, 16'h3766});
        chk("model_sub_neg", ref_calc(16'h1234, 16'h5000, 1'b1, 1'b1), {2'b00, 16'h6234});
        chk("model_bad", ref_calc(16'h12A4, 16'h0000, 1'b0, 1'b0), {2'b10, 16'h0000});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_req("add", 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
        run_req("ripple", 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_req("ripple_cin", 16'h9999, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_req("sub_pos", 16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0);
        run_req("sub_neg", 16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0, 1'b0);
        run_req("sub_eq", 16'h4321, 16'h4321, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_req("bad", 16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

        // start in second RUN cycle is ignored
        @(negedge clk);
        bus.a = 16'h5000; bus.b = 16'h1234; bus.op = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 16'h9999; bus.b = 16'h9999; bus.op = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignore");
        chk("ignore_res", bus.result, 16'h3766);
        chk("ignore_cout", bus.cout, 1);

        // start held through DONE launches the next request at once
        @(negedge clk);
        bus.a = 16'h1234; bus.b = 16'h5678; bus.op = 1'b0; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a = 16'h0042; bus.b = 16'h0058; bus.cin = 1'b1;
        wait_done("held_a");
        chk("held_a_res", bus.result, 16'h6912);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        chk("held_b_busy", bus.busy, 1);
        wait_done("held_b");
        chk("held_b_res", bus.result, 16'h0101);
        chk("held_b_cout", bus.cout, 0);

        // asynchronous reset in the third RUN cycle
        @(negedge clk);
        bus.a = 16'h9999; bus.b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outputs", {bus.busy, bus.done, bus.cout, bus.err, bus.result}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int dn = 0;
            repeat (6) begin
                @(negedge clk);
                dn += int'(bus.done);
            end
            chk("rst_no_done", dn, 0);
        end
        run_req("after_rst", 16'h0500, 16'h0499, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);

        // randomized traffic against the model
        repeat (1500) begin
            @(negedge clk);
            bus.a = rand_bcd(); bus.b = rand_bcd();
            bus.op = 1'($urandom_range(0, 1)); bus.cin = 1'($urandom_range(0, 1));
            bus.start = ($urandom_range(0, 2) == 0);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
